// File: rtl/jericalla_issue_unit.sv
// Issue front-end for the 3-stage Jericalla pipeline: program memory, PC, and
// RAW-hazard bubble insertion against the two most recently issued words.
module jericalla_issue_unit #(
    parameter int          AW       = 5,
    parameter logic [16:0] NOP_INST = 17'h00000,
    parameter logic [3:0]  WE_MASK  = 4'b1110
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_prog_we,
    input  logic [AW-1:0] i_prog_addr,
    input  logic [16:0]   i_prog_data,
    input  logic [AW:0]   i_prog_len,
    input  logic          i_start,
    output logic [16:0]   o_inst,
    output logic          o_issue_vld,
    output logic [AW:0]   o_pc,
    output logic          o_busy,
    output logic          o_done,
    output logic [15:0]   o_stall_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [16:0]   r_mem [2**AW];
    logic [1:0]    r_state;
    logic [AW:0]   r_pc;
    logic [AW:0]   r_len;
    logic [15:0]   r_stall_cnt;
    logic          r_drain_cnt;
    // _p0 is the word on INST (slot S1), _p1 the word issued before it (slot S2)
    logic [16:0]   r_inst_p0;
    logic          r_vld_p0;
    logic [16:0]   r_inst_p1;
    logic          r_vld_p1;

    logic [16:0]   w_cand;
    logic [AW:0]   w_pc_next;
    logic          w_hazard;
    logic          w_loadable;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic slot_wr(input logic [16:0] w, input logic vld);
        return vld && WE_MASK[w[16:15]];
    endfunction

    function automatic logic reads_reg(input logic [16:0] c, input logic [4:0] wa);
        return (c[9:5] == wa) || (c[4:0] == wa);
    endfunction

    assign w_cand     = r_mem[r_pc[AW-1:0]];
    assign w_pc_next  = r_pc + 1'b1;
    assign w_loadable = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_hazard   = (slot_wr(r_inst_p0, r_vld_p0) && reads_reg(w_cand, r_inst_p0[14:10]))
                     || (slot_wr(r_inst_p1, r_vld_p1) && reads_reg(w_cand, r_inst_p1[14:10]));

    // Program memory is deliberately outside the reset domain.
    always_ff @(posedge i_clk) begin
        if (i_prog_we && w_loadable) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_len       <= '0;
            r_stall_cnt <= '0;
            r_drain_cnt <= 1'b0;
            r_inst_p0   <= NOP_INST;
            r_vld_p0    <= 1'b0;
            r_inst_p1   <= NOP_INST;
            r_vld_p1    <= 1'b0;
        end else begin
            // ---- stage boundary: S1 ages into S2, new word (or bubble) into S1
            r_inst_p1 <= r_inst_p0;
            r_vld_p1  <= r_vld_p0;
            r_inst_p0 <= NOP_INST;
            r_vld_p0  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_len       <= i_prog_len;
                        r_pc        <= '0;
                        r_stall_cnt <= '0;
                        r_drain_cnt <= 1'b0;
                        r_state     <= (i_prog_len == '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_hazard) begin
                        r_stall_cnt <= sat_inc(r_stall_cnt);
                    end else begin
                        r_inst_p0 <= w_cand;
                        r_vld_p0  <= 1'b1;
                        r_pc      <= w_pc_next;
                        if (w_pc_next == r_len) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= 1'b0;
                        end
                    end
                end
                default: begin
                    // Leave DRAIN after two bubble cycles have been on INST.
                    if (!r_vld_p0) begin
                        if (r_drain_cnt) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_drain_cnt <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_inst      = r_inst_p0;
    assign o_issue_vld = r_vld_p0;
    assign o_pc        = r_pc;
    assign o_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done      = (r_state == ST_DONE);
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_jericalla_issue_unit.sv
// Scoreboard bench for jericalla_issue_unit: expected issued words and their
// cycle offsets are queued by the stimulus and checked by an independent monitor.
module tb_jericalla_issue_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [16:0]   prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic [16:0]   o_inst;
    logic          o_issue_vld;
    logic [AW:0]   o_pc;
    logic          o_busy;
    logic          o_done;
    logic [15:0]   o_stall_cnt;

    jericalla_issue_unit #(.AW(AW), .NOP_INST(17'h00000), .WE_MASK(4'b1110)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr),
        .i_prog_data (prog_data),
        .i_prog_len  (prog_len),
        .i_start     (start),
        .o_inst      (o_inst),
        .o_issue_vld (o_issue_vld),
        .o_pc        (o_pc),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_stall_cnt (o_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] word;
        int          off;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   start_cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [16:0] prog [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] mk(input int op, input int wa, input int ra1, input int ra2);
        logic [16:0] w;
        w = {op[1:0], wa[4:0], ra1[4:0], ra2[4:0]};
        return w;
    endfunction

    // Monitor: every valid issue must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst === 1'b0 && o_issue_vld === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_issue: got inst=%05h, required no issue", o_inst);
            end else begin
                mon_e = q.pop_front();
                chk("issue_word", o_inst, mon_e.word);
                chk("issue_cycle", cyc - start_cyc, mon_e.off);
            end
        end
    end

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = i[AW-1:0];
            prog_data = prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        start    = 1'b1;
        prog_len = len[AW:0];
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && o_done !== 1'b1; i++) @(negedge clk);
        chk(name, o_done, 1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_inst", o_inst, 0);
        chk("rst_vld", o_issue_vld, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_stall", o_stall_cnt, 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Three independent words, back-to-back
        prog[0] = mk(1, 1, 4, 5);
        prog[1] = mk(2, 2, 6, 7);
        prog[2] = mk(3, 3, 4, 6);
        load(3);
        q.push_back('{prog[0], 1});
        q.push_back('{prog[1], 2});
        q.push_back('{prog[2], 3});
        do_start(3);
        repeat (5) @(negedge clk);
        chk("t2_done_early", o_done, 0);
        chk("t2_busy_drain", o_busy, 1);
        @(negedge clk);
        chk("t2_done", o_done, 1);
        chk("t2_busy_off", o_busy, 0);
        chk("t2_stall", o_stall_cnt, 0);
        chk("t2_pc", o_pc, 3);
        chk("t2_q_empty", q.size(), 0);

        // Distance-1 dependency: two bubbles
        prog[0] = mk(1, 5, 8, 9);
        prog[1] = mk(2, 6, 5, 10);
        load(2);
        q.push_back('{prog[0], 1});
        q.push_back('{prog[1], 4});
        do_start(2);
        repeat (2) @(negedge clk);
        chk("t3_pc_hold_a", o_pc, 1);
        chk("t3_bubble_a", o_issue_vld, 0);
        @(negedge clk);
        chk("t3_pc_hold_b", o_pc, 1);
        chk("t3_stall_mid", o_stall_cnt, 2);
        wait_done("t3_done", 20);
        chk("t3_stall", o_stall_cnt, 2);
        chk("t3_q_empty", q.size(), 0);

        // Distance-2 dependency on RA2: one bubble
        prog[0] = mk(2, 5, 8, 9);
        prog[1] = mk(3, 6, 10, 11);
        prog[2] = mk(1, 7, 12, 5);
        load(3);
        q.push_back('{prog[0], 1});
        q.push_back('{prog[1], 2});
        q.push_back('{prog[2], 4});
        do_start(3);
        wait_done("t4_done", 20);
        chk("t4_stall", o_stall_cnt, 1);
        chk("t4_q_empty", q.size(), 0);

        // Opcode 00 does not write: no stall
        prog[0] = mk(0, 5, 8, 9);
        prog[1] = mk(1, 6, 5, 10);
        load(2);
        q.push_back('{prog[0], 1});
        q.push_back('{prog[1], 2});
        do_start(2);
        wait_done("t5_done", 20);
        chk("t5_stall", o_stall_cnt, 0);
        chk("t5_q_empty", q.size(), 0);

        // Program write during RUN is ignored
        prog[0] = mk(1, 1, 8, 9);
        prog[1] = mk(1, 2, 10, 11);
        prog[2] = mk(1, 3, 12, 13);
        prog[3] = mk(1, 4, 14, 15);
        load(4);
        for (int i = 0; i < 4; i++) q.push_back('{prog[i], i + 1});
        do_start(4);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 5'd2;
        prog_data = mk(3, 31, 31, 31);
        @(negedge clk);
        prog_we = 1'b0;
        wait_done("t6_done", 20);
        chk("t6_q_empty", q.size(), 0);

        // Zero-length program: two drain cycles then DONE
        do_start(0);
        chk("t6z_busy", o_busy, 1);
        @(negedge clk);
        chk("t6z_done_early", o_done, 0);
        chk("t6z_vld", o_issue_vld, 0);
        @(negedge clk);
        chk("t6z_done", o_done, 1);

        // Asynchronous reset mid-run
        q.push_back('{prog[0], 1});
        q.push_back('{prog[1], 2});
        do_start(4);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rr_inst", o_inst, 0);
        chk("rr_vld", o_issue_vld, 0);
        chk("rr_pc", o_pc, 0);
        chk("rr_busy", o_busy, 0);
        chk("rr_done", o_done, 0);
        chk("rr_q_empty", q.size(), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rr_idle_busy", o_busy, 0);
        chk("rr_idle_done", o_done, 0);
        chk("rr_idle_pc", o_pc, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
